// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling on a clk-derived bit counter,
// one-cycle valid / frame_err strobes for fabric logic.
module uart_rx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int HALF_BIT     = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    shreg, shreg_n;
   logic [7:0]    data_n;
   logic          valid_n, frame_err_n;
   logic          rx_meta, rx_s;
   logic          bit_end, half_end;

   // Synchronizer resets to 1 so a reset never looks like a start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the pre-edge value, so the
         // two stages really are two clocks apart regardless of statement order.
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   assign bit_end  = (cnt == CW'(CLKS_PER_BIT - 1));
   assign half_end = (cnt == CW'(HALF_BIT - 1));
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bit_idx   <= bit_idx_n;
         shreg     <= shreg_n;
         data      <= data_n;
         valid     <= valid_n;
         frame_err <= frame_err_n;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can leave a
      // value unassigned and infer a latch.
      state_n     = state;
      cnt_n       = cnt;
      bit_idx_n   = bit_idx;
      shreg_n     = shreg;
      data_n      = data;
      valid_n     = 1'b0;
      frame_err_n = 1'b0;

      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (!rx_s) state_n = START;
         end
         START: begin
            if (half_end) begin
               cnt_n = '0;
               if (rx_s) begin
                  state_n = IDLE;
               end else begin
                  state_n   = DATA;
                  bit_idx_n = '0;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_n   = '0;
               shreg_n = {rx_s, shreg[7:1]};
               if (bit_idx == 3'd7) state_n = STOP;
               else                 bit_idx_n = bit_idx + 3'd1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_n = '0;
               if (rx_s) begin
                  data_n  = shreg;
                  valid_n = 1'b1;
                  state_n = IDLE;
               end else begin
                  frame_err_n = 1'b1;
                  state_n     = BREAK;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         BREAK: begin
            // A held-low line is a break, not a stream of zero bytes.
            cnt_n = '0;
            if (rx_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx at 16 clk/bit; a queue-based frame model predicts
// the received byte stream, framing errors and strobe timing.
module tb_uart_rx;

   localparam int CPB    = 16;
   localparam int HALF   = 8;
   localparam int CLK_NS = 10;
   localparam int BIT_NS = CPB * CLK_NS;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   always #(CLK_NS / 2) clk = ~clk;

   uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Observation side: posedge count, and strobes sampled on the falling edge.
   int         cycle          = 0;
   logic [7:0] got_q[$];
   int         valid_cnt      = 0;
   int         ferr_cnt       = 0;
   int         both_cnt       = 0;
   int         last_valid_cyc = -1;
   int         busy_fall_cyc  = -1;
   logic       busy_prev      = 1'b0;

   always @(posedge clk) cycle <= cycle + 1;

   always @(negedge clk) begin
      if (valid) begin
         got_q.push_back(data);
         valid_cnt      <= valid_cnt + 1;
         last_valid_cyc <= cycle;
      end
      if (frame_err)          ferr_cnt      <= ferr_cnt + 1;
      if (valid && frame_err) both_cnt      <= both_cnt + 1;
      if (busy_prev && !busy) busy_fall_cyc <= cycle;
      busy_prev <= busy;
   end

   // Reference model: a well-framed byte is expected in order; a low stop bit is one error.
   logic [7:0] exp_q[$];
   int         exp_ferr = 0;
   logic [7:0] exp_data = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one 8N1 frame with a bit time in ns, so off-nominal baud rates are possible.
   task automatic send_frame(input logic [7:0] b, input int bit_ns, input logic stop_bit);
      rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #(bit_ns);
      end
      rx = stop_bit;
      #(bit_ns);
      if (stop_bit) begin
         exp_q.push_back(b);
         exp_data = b;
      end else begin
         exp_ferr++;
      end
   endtask

   task automatic compare_stream(input string tag);
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] burst[3];
      logic [7:0] c3;
      int         periods[3];
      int         fall_cyc;
      logic [7:0] rb;
      int         rp;

      burst   = '{8'h00, 8'hFF, 8'h55};
      periods = '{BIT_NS, BIT_NS - 5, BIT_NS + 5};
      c3      = 8'hC3;

      // Reset with the line idle.
      rx  = 1'b1;
      rst = 1'b1;
      #23;
      check("rst_data",  32'(data),      32'h00);
      check("rst_valid", 32'(valid),     32'h0);
      check("rst_ferr",  32'(frame_err), 32'h0);
      check("rst_busy",  32'(busy),      32'h0);
      @(negedge clk);
      rst = 1'b0;
      idle(200);
      check("idle_valid_cnt", 32'(valid_cnt), 32'd0);
      check("idle_ferr_cnt",  32'(ferr_cnt),  32'd0);
      check("idle_busy",      32'(busy),      32'h0);

      // Single byte with strobe latency measured from the pin fall.
      @(negedge clk);
      fall_cyc = cycle;
      send_frame(8'hA5, BIT_NS, 1'b1);
      idle(20);
      check("a5_valid_cnt", 32'(valid_cnt), 32'd1);
      check("a5_data",      32'(data),      32'h A5);
      check("a5_latency",   32'(last_valid_cyc - fall_cyc), 32'd155);
      check("a5_busy_fall", 32'(busy_fall_cyc - fall_cyc),  32'd155);

      // Short low glitch is dropped, then a normal frame follows.
      rx = 1'b0;
      idle(5);
      rx = 1'b1;
      idle(30);
      check("glitch_busy",      32'(busy),      32'h0);
      check("glitch_valid_cnt", 32'(valid_cnt), 32'd1);
      check("glitch_ferr_cnt",  32'(ferr_cnt),  32'd0);
      send_frame(8'h3C, BIT_NS, 1'b1);
      idle(20);
      check("3c_data", 32'(data), 32'(exp_data));

      // Bad stop bit followed by a held-low line.
      send_frame(8'h81, BIT_NS, 1'b0);
      idle(40);
      check("brk_busy",      32'(busy),      32'h1);
      check("brk_ferr_cnt",  32'(ferr_cnt),  32'(exp_ferr));
      check("brk_valid_cnt", 32'(valid_cnt), 32'(exp_q.size()));
      check("brk_data",      32'(data),      32'(exp_data));
      rx = 1'b1;
      idle(5);
      check("brk_release_busy", 32'(busy),     32'h0);
      check("brk_release_ferr", 32'(ferr_cnt), 32'(exp_ferr));

      // Back-to-back bursts at nominal and +/-3% bit time (15.5 and 16.5 clk).
      for (int p = 0; p < 3; p++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) send_frame(burst[k], periods[p], 1'b1);
         idle(20);
         check("b2b_valid_cnt", 32'(valid_cnt), 32'(exp_q.size()));
      end
      compare_stream("b2b");

      // Random bytes, random phase and bit time, zero idle gap.
      #($urandom_range(0, CLK_NS - 1));
      for (int n = 0; n < 8; n++) begin
         rb = 8'($urandom);
         rp = BIT_NS - 5 + 5 * $urandom_range(0, 2);
         send_frame(rb, rp, 1'b1);
      end
      idle(20);
      check("rand_data", 32'(data), 32'(exp_data));
      compare_stream("rand");

      // Reset in the middle of data bit 4; the partial byte must vanish.
      @(negedge clk);
      rx = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 4; i++) begin
         rx = c3[i];
         #(BIT_NS);
      end
      rx = c3[4];
      #(BIT_NS / 2);
      rst = 1'b1;
      #3;
      exp_data = 8'h00;
      check("midrst_data",  32'(data),      32'(exp_data));
      check("midrst_valid", 32'(valid),     32'h0);
      check("midrst_ferr",  32'(frame_err), 32'h0);
      check("midrst_busy",  32'(busy),      32'h0);
      rx = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle(20);
      check("midrst_valid_cnt", 32'(valid_cnt), 32'(exp_q.size()));
      send_frame(8'h96, BIT_NS, 1'b1);
      idle(20);
      check("96_data", 32'(data), 32'(exp_data));
      compare_stream("final");
      check("final_ferr_cnt", 32'(ferr_cnt), 32'(exp_ferr));
      check("never_both",     32'(both_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
